// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Streams up to 16 program bytes from a valid/ready byte source
//               into a 16-entry RAM through its manual-mode write port.
//               A session starts at start_addr and writes one byte per
//               address up to and including address 15. It ends with a
//               one-cycle done pulse when address 15 is written. It ends
//               with a sticky error if the source stalls for TIMEOUT_CYCLES
//               consecutive cycles. It ends silently on abort.
// Ports       : clk, rst_n        - clock, async active-low reset
//               start, start_addr - launch a session at the given address
//               abort             - end the active session
//               byte_valid/_data  - byte source; byte_ready is the handshake
//               ram_address/_data - RAM write address and data
//               manual_mode       - RAM held in manual mode (session active)
//               manual_read       - one-cycle RAM write strobe
//               busy, done, error - session status
//               bytes_loaded      - bytes written in the current/last session
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] start_addr,
    input  logic       abort,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic [3:0] ram_address,
    output logic [7:0] ram_data,
    output logic       manual_mode,
    output logic       manual_read,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] bytes_loaded
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_WAIT_BYTE = 3'd1;
    localparam logic [2:0] c_WRITE     = 3'd2;
    localparam logic [2:0] c_DONE      = 3'd3;
    localparam logic [2:0] c_ERROR     = 3'd4;

    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_rst_sync;
    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [15:0] r_tmo;
    logic        r_byte_ready;
    logic [3:0]  r_ram_address;
    logic [7:0]  r_ram_data;
    logic        r_manual_mode;
    logic        r_manual_read;
    logic        r_done;
    logic        r_error;
    logic [4:0]  r_bytes_loaded;
    logic        w_run;
    logic        w_hs;
    logic        w_idle_like;

    // Reset asserts asynchronously but releases through two flops. The FSM
    // therefore cannot move before the third rising edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run       = r_rst_sync[1];
    assign w_hs        = r_byte_ready & byte_valid;
    assign w_idle_like = (r_state == c_IDLE) || (r_state == c_DONE) ||
                         (r_state == c_ERROR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE, c_DONE, c_ERROR: begin
                // abort has no meaning here, so start wins over it.
                if (start) begin
                    w_state_nxt = c_WAIT_BYTE;
                end else if (r_state == c_DONE) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_WAIT_BYTE: begin
                // abort beats a same-cycle handshake; that byte is dropped.
                if (abort) begin
                    w_state_nxt = c_IDLE;
                end else if (w_hs) begin
                    w_state_nxt = c_WRITE;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_state_nxt = c_ERROR;
                end
            end
            c_WRITE: begin
                if (abort) begin
                    w_state_nxt = c_IDLE;
                end else if (r_ram_address == 4'd15) begin
                    w_state_nxt = c_DONE;
                end else begin
                    w_state_nxt = c_WAIT_BYTE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Status outputs are registered from the next state. Each output then
    // lines up exactly with the state it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_IDLE;
            r_tmo          <= 16'd0;
            r_byte_ready   <= 1'b0;
            r_ram_address  <= 4'd0;
            r_ram_data     <= 8'd0;
            r_manual_mode  <= 1'b0;
            r_manual_read  <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_bytes_loaded <= 5'd0;
        end else if (w_run) begin
            r_state       <= w_state_nxt;
            r_byte_ready  <= (w_state_nxt == c_WAIT_BYTE);
            r_manual_mode <= (w_state_nxt == c_WAIT_BYTE) ||
                             (w_state_nxt == c_WRITE);
            r_manual_read <= (w_state_nxt == c_WRITE);
            r_done        <= (w_state_nxt == c_DONE);

            if (w_idle_like && start) begin
                r_ram_address  <= start_addr;
                r_bytes_loaded <= 5'd0;
                r_error        <= 1'b0;
                r_tmo          <= 16'd0;
            end

            if ((r_state == c_WAIT_BYTE) && !abort) begin
                if (w_hs) begin
                    r_ram_data <= byte_data;
                    r_tmo      <= 16'd0;
                end else if (r_tmo == c_TMO_LAST) begin
                    r_error <= 1'b1;
                end else begin
                    r_tmo <= r_tmo + 16'd1;
                end
            end

            // The strobe is already on the RAM pins, so the byte counts even
            // if abort arrives. The address stays put once the session ends.
            if (r_state == c_WRITE) begin
                r_bytes_loaded <= r_bytes_loaded + 5'd1;
                if (!abort && (r_ram_address != 4'd15)) begin
                    r_ram_address <= r_ram_address + 4'd1;
                end
            end
        end
    end

    assign byte_ready   = r_byte_ready;
    assign ram_address  = r_ram_address;
    assign ram_data     = r_ram_data;
    assign manual_mode  = r_manual_mode;
    assign manual_read  = r_manual_read;
    assign busy         = r_manual_mode;
    assign done         = r_done;
    assign error        = r_error;
    assign bytes_loaded = r_bytes_loaded;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Scoreboard bench for program_loader. Stimulus pushes the
//               expected RAM writes and done counts into queues. A monitor
//               pops and compares them whenever the DUT strobes
//               manual_read or pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] start_addr = 4'd0;
    logic       abort = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;
    logic       byte_ready;
    logic [3:0] ram_address;
    logic [7:0] ram_data;
    logic       manual_mode;
    logic       manual_read;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] bytes_loaded;

    program_loader #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .abort       (abort),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .manual_mode (manual_mode),
        .manual_read (manual_read),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .bytes_loaded(bytes_loaded)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [11:0] exp_wr[$];
    int          exp_done[$];
    int          strobe_cyc[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe and every done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (manual_read === 1'b1) begin
                strobe_cyc.push_back(cyc);
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", {20'd0, ram_address, ram_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [11:0] e;
                    e = exp_wr.pop_front();
                    chk("write_addr", ram_address, e[11:8]);
                    chk("write_data", ram_data, e[7:0]);
                    chk("write_mode", manual_mode, 1);
                end
            end
            if (done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", bytes_loaded, 32'hFFFF_FFFF);
                end else begin
                    int d;
                    d = exp_done.pop_front();
                    chk("done_count", bytes_loaded, d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] a, input logic ab);
        start      = 1'b1;
        start_addr = a;
        abort      = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", byte_ready, 1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (byte_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (byte_ready !== 1'b1) chk("ready_timeout", byte_ready, 1);
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = d;
        wait_ready();
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("done_seen", done, 1);
        tick();
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_mode", manual_mode, 0);
        chk("rst_read", manual_read, 0);
        chk("rst_ready", byte_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_data", ram_data, 0);
        chk("rst_count", bytes_loaded, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Full 16-byte session from address 0, byte_valid effectively held
        strobe_cyc.delete();
        do_start(4'd0, 1'b0);
        for (int i = 0; i < 16; i++) exp_wr.push_back({4'(i), 8'(i)});
        exp_done.push_back(16);
        for (int i = 0; i < 16; i++) send(8'(i), 0);
        wait_done();
        chk("full_count", bytes_loaded, 16);
        chk("full_mode", manual_mode, 0);
        chk("full_busy", busy, 0);
        chk("full_addr", ram_address, 15);
        chk("full_done_1cyc", done, 0);
        chk("full_strobes", strobe_cyc.size(), 16);
        begin
            int bad;
            bad = 0;
            for (int i = 1; i < strobe_cyc.size(); i++)
                if (strobe_cyc[i] - strobe_cyc[i-1] != 2) bad++;
            chk("full_period", bad, 0);
        end

        // Session from address 14: only two writes
        do_start(4'd14, 1'b0);
        exp_wr.push_back({4'd14, 8'hAA});
        exp_wr.push_back({4'd15, 8'h55});
        exp_done.push_back(2);
        send(8'hAA, 0);
        send(8'h55, 0);
        wait_done();
        chk("b14_count", bytes_loaded, 2);
        repeat (3) tick();
        chk("b14_addr_hold", ram_address, 15);
        chk("b14_data_hold", ram_data, 8'h55);

        // Timeout: 8 WAIT_BYTE cycles with no byte
        do_start(4'd3, 1'b0);
        repeat (7) tick();
        chk("tmo_err_early", error, 0);
        chk("tmo_busy_early", busy, 1);
        tick();
        chk("tmo_error", error, 1);
        chk("tmo_mode", manual_mode, 0);
        chk("tmo_busy", busy, 0);
        chk("tmo_ready", byte_ready, 0);
        repeat (2) tick();
        chk("tmo_sticky", error, 1);

        // Abort together with the handshake of the fourth byte
        do_start(4'd0, 1'b0);
        chk("abort_err_clr", error, 0);
        for (int i = 0; i < 3; i++) exp_wr.push_back({4'(i), 8'(8'h10 + i)});
        for (int i = 0; i < 3; i++) send(8'(8'h10 + i), 0);
        byte_valid = 1'b1;
        byte_data  = 8'h13;
        wait_ready();
        abort = 1'b1;
        chk("abort_ready", byte_ready, 1);
        tick();
        abort      = 1'b0;
        byte_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_count", bytes_loaded, 3);
        chk("abort_done", done, 0);
        chk("abort_strobe", manual_read, 0);
        chk("abort_addr", ram_address, 3);
        chk("abort_data", ram_data, 8'h12);
        repeat (2) tick();

        // Reset during the WRITE cycle
        do_start(4'd5, 1'b0);
        send(8'h77, 0);
        chk("wr_strobe_on", manual_read, 1);
        rst_n = 1'b0;
        #1;
        chk("rstw_read", manual_read, 0);
        chk("rstw_mode", manual_mode, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_addr", ram_address, 0);
        chk("rstw_data", ram_data, 0);
        chk("rstw_count", bytes_loaded, 0);
        #10;
        rst_n      = 1'b1;
        start      = 1'b1;
        start_addr = 4'd12;
        tick();
        tick();
        chk("rel_sync_hold", busy, 0);
        tick();
        start = 1'b0;
        chk("rel_start", busy, 1);
        for (int i = 0; i < 4; i++) exp_wr.push_back({4'(12 + i), 8'(8'hC0 + i)});
        exp_done.push_back(4);
        for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), 0);
        wait_done();
        chk("rel_count", bytes_loaded, 4);

        // Start and abort together while idle, then random source gaps
        do_start(4'd2, 1'b1);
        for (int i = 0; i < 14; i++) exp_wr.push_back({4'(2 + i), 8'(8'h30 + i)});
        exp_done.push_back(14);
        for (int i = 0; i < 14; i++) send(8'(8'h30 + i), int'($urandom_range(0, 5)));
        wait_done();
        chk("gap_count", bytes_loaded, 14);
        chk("gap_error", error, 0);

        repeat (3) tick();
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
